// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: majority-vote bit sampling, false-start rejection,
// parity/framing/break detection and a one-entry valid/ready output register.
module uart_rx_param #(
   parameter int DATA   = 8,
   parameter int PARITY = 0,
   parameter int STOP   = 1,
   parameter int OSR    = 16
) (
   input  logic            i_divided_clk,
   input  logic            i_rst,
   input  logic            i_en,
   input  logic            i_rx,
   input  logic            i_ready,
   output logic [DATA-1:0] o_data,
   output logic            o_valid,
   output logic            o_parity_err,
   output logic            o_frame_err,
   output logic            o_break,
   output logic            o_overrun,
   output logic            o_busy
);
   localparam int M  = OSR / 2;
   localparam int TW = $clog2(OSR);
   localparam int BW = $clog2(DATA + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
   } state_t;

   typedef struct packed {
      logic [DATA-1:0] data;
      logic            parity_err;
      logic            frame_err;
      logic            brk;
   } frame_t;

   state_t          state;
   logic            sync1, rs, rs_prev;
   logic [TW-1:0]   tick;
   logic [BW-1:0]   bit_cnt;
   logic [DATA-1:0] shreg;
   logic            smp_a, smp_b;
   logic            par_acc, frm_acc, any_one;
   logic            pend;
   frame_t          pend_frm;
   logic            maj, tick_dec, tick_last, last_bit, last_stop, par_err;

   assign maj       = (smp_a & smp_b) | (smp_a & rs) | (smp_b & rs);
   assign tick_dec  = (tick == TW'(M + 1));
   assign tick_last = (tick == TW'(OSR - 1));
   assign last_bit  = (bit_cnt == BW'(DATA - 1));
   assign last_stop = (bit_cnt == BW'(STOP - 1));
   // par_acc holds XOR of data bits and the parity sample by the time STOP is reached
   assign par_err   = (PARITY != 0) && (par_acc != (PARITY == 1));

   always_ff @(posedge i_divided_clk or posedge i_rst) begin
      if (i_rst) begin
         sync1   <= 1'b1;
         rs      <= 1'b1;
         rs_prev <= 1'b1;
      end else begin
         sync1   <= i_rx;
         rs      <= sync1;
         rs_prev <= rs;
      end
   end

   always_ff @(posedge i_divided_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= S_IDLE;
         tick     <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         smp_a    <= 1'b0;
         smp_b    <= 1'b0;
         par_acc  <= 1'b0;
         frm_acc  <= 1'b0;
         any_one  <= 1'b0;
         pend     <= 1'b0;
         pend_frm <= '0;
         o_busy   <= 1'b0;
      end else begin
         pend <= 1'b0;
         if (i_en) begin
            if (state != S_IDLE && state != S_WAIT_HIGH) begin
               tick <= tick_last ? '0 : tick + TW'(1);
               if (tick == TW'(M - 1)) smp_a <= rs;
               if (tick == TW'(M))     smp_b <= rs;
            end
            case (state)
               S_IDLE: begin
                  if (!rs && rs_prev) begin
                     state   <= S_START;
                     tick    <= '0;
                     par_acc <= 1'b0;
                     frm_acc <= 1'b0;
                     any_one <= 1'b0;
                     o_busy  <= 1'b1;
                  end
               end
               S_START: begin
                  if (tick_dec && maj) begin
                     state  <= S_IDLE;
                     tick   <= '0;
                     o_busy <= 1'b0;
                  end else if (tick_last) begin
                     state   <= S_DATA;
                     bit_cnt <= '0;
                  end
               end
               S_DATA: begin
                  if (tick_dec) begin
                     for (int i = 0; i < DATA; i++)
                        if (bit_cnt == BW'(i)) shreg[i] <= maj;
                     par_acc <= par_acc ^ maj;
                     any_one <= any_one | maj;
                  end
                  if (tick_last) begin
                     if (last_bit) begin
                        state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        bit_cnt <= '0;
                     end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                     end
                  end
               end
               S_PARITY: begin
                  if (tick_dec) begin
                     par_acc <= par_acc ^ maj;
                     any_one <= any_one | maj;
                  end
                  if (tick_last) begin
                     state   <= S_STOP;
                     bit_cnt <= '0;
                  end
               end
               S_STOP: begin
                  if (tick_dec) begin
                     if (last_stop) begin
                        // leave mid-bit so the next start edge can arrive up to half a bit early
                        pend                <= 1'b1;
                        pend_frm.data       <= shreg;
                        pend_frm.parity_err <= par_err;
                        pend_frm.frame_err  <= frm_acc | !maj;
                        pend_frm.brk        <= !(any_one | maj);
                        state               <= maj ? S_IDLE : S_WAIT_HIGH;
                        tick                <= '0;
                        o_busy              <= !maj;
                     end else begin
                        frm_acc <= frm_acc | !maj;
                        any_one <= any_one | maj;
                     end
                  end else if (tick_last) begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end
               S_WAIT_HIGH: begin
                  if (rs) begin
                     state  <= S_IDLE;
                     o_busy <= 1'b0;
                  end
               end
               default: begin
                  state  <= S_IDLE;
                  o_busy <= 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge i_divided_clk or posedge i_rst) begin
      if (i_rst) begin
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         o_break      <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         if (o_valid && i_ready) begin
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
         end
         if (pend) begin
            if (!o_valid || i_ready) begin
               o_data       <= pend_frm.data;
               o_parity_err <= pend_frm.parity_err;
               o_frame_err  <= pend_frm.frame_err;
               o_break      <= pend_frm.brk;
               o_valid      <= 1'b1;
            end else begin
               o_overrun <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 8E1, 8N2) driven with directed frames,
// checked against a frame-level model queue plus literal expectations.
module tb_uart_rx_param;
   localparam int OSR = 16;

   typedef struct packed {
      logic [1:0] u;
      logic [7:0] data;
      logic       pe;
      logic       fe;
      logic       brk;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst, en;
   logic [2:0]      rx, rdy, vld, pe, fe, brk, ovr, bsy;
   logic [2:0][7:0] dat;
   int              checks = 0;
   int              errors = 0;
   exp_t            exp_q[$];
   logic [2:0]      prev_v, prev_hs;
   exp_t            held[3];

   always #5 clk = ~clk;

   uart_rx_param #(.DATA(8), .PARITY(0), .STOP(1), .OSR(OSR)) u_n1 (
      .i_divided_clk(clk), .i_rst(rst), .i_en(en), .i_rx(rx[0]), .i_ready(rdy[0]),
      .o_data(dat[0]), .o_valid(vld[0]), .o_parity_err(pe[0]), .o_frame_err(fe[0]),
      .o_break(brk[0]), .o_overrun(ovr[0]), .o_busy(bsy[0]));

   uart_rx_param #(.DATA(8), .PARITY(2), .STOP(1), .OSR(OSR)) u_e1 (
      .i_divided_clk(clk), .i_rst(rst), .i_en(en), .i_rx(rx[1]), .i_ready(rdy[1]),
      .o_data(dat[1]), .o_valid(vld[1]), .o_parity_err(pe[1]), .o_frame_err(fe[1]),
      .o_break(brk[1]), .o_overrun(ovr[1]), .o_busy(bsy[1]));

   uart_rx_param #(.DATA(8), .PARITY(0), .STOP(2), .OSR(OSR)) u_n2 (
      .i_divided_clk(clk), .i_rst(rst), .i_en(en), .i_rx(rx[2]), .i_ready(rdy[2]),
      .o_data(dat[2]), .o_valid(vld[2]), .o_parity_err(pe[2]), .o_frame_err(fe[2]),
      .o_break(brk[2]), .o_overrun(ovr[2]), .o_busy(bsy[2]));

   function automatic int par_of(input int u);
      return (u == 1) ? 2 : 0;
   endfunction

   function automatic int nstop_of(input int u);
      return (u == 2) ? 2 : 1;
   endfunction

   // Expected report for one frame, straight from the line-level definitions
   function automatic exp_t model_frame(input int u, input logic [7:0] d, input logic pbit,
                                        input logic [1:0] stops);
      exp_t e;
      int   ones;
      logic stops_zero;
      ones       = $countones(d) + ((par_of(u) != 0) ? int'(pbit) : 0);
      stops_zero = (stops[0] == 1'b0) && (nstop_of(u) == 1 || stops[1] == 1'b0);
      e.u    = 2'(u);
      e.data = d;
      e.pe   = (par_of(u) != 0) && ((ones % 2) != ((par_of(u) == 1) ? 1 : 0));
      e.fe   = (stops[0] == 1'b0) || (nstop_of(u) == 2 && stops[1] == 1'b0);
      e.brk  = (d == 8'h00) && (par_of(u) == 0 || pbit == 1'b0) && stops_zero;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input int u, input logic b);
      rx[u] = b;
      cycles(OSR);
   endtask

   task automatic send_frame(input int u, input logic [7:0] d, input logic pbit,
                             input logic [1:0] stops, input bit expect_out);
      if (expect_out) exp_q.push_back(model_frame(u, d, pbit, stops));
      drive_bit(u, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(u, d[i]);
      if (par_of(u) != 0) drive_bit(u, pbit);
      for (int i = 0; i < nstop_of(u); i++) drive_bit(u, stops[i]);
      rx[u] = 1'b1;
      cycles(2 * OSR);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 4 * OSR) begin
         cycles(1);
         n++;
      end
      chk(name, 64'(exp_q.size()), 64'd0);
   endtask

   // A new frame is in the register when valid is high and the slot was empty or just freed
   always @(negedge clk) begin
      if (rst) begin
         prev_v  <= '0;
         prev_hs <= '0;
      end else begin
         for (int u = 0; u < 3; u++) begin
            if (vld[u] && (!prev_v[u] || prev_hs[u])) begin
               if (exp_q.size() == 0 || exp_q[0].u != 2'(u)) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame_u%0d: got data 0x%0h, required no frame", u, dat[u]);
               end else begin
                  chk($sformatf("frame_u%0d", u), {dat[u], pe[u], fe[u], brk[u]},
                      {exp_q[0].data, exp_q[0].pe, exp_q[0].fe, exp_q[0].brk});
                  held[u] <= exp_q[0];
                  void'(exp_q.pop_front());
               end
            end else if (vld[u] && prev_v[u]) begin
               chk($sformatf("hold_u%0d", u), {dat[u], pe[u], fe[u], brk[u]},
                   {held[u].data, held[u].pe, held[u].fe, held[u].brk});
            end
         end
         prev_v  <= vld;
         prev_hs <= vld & rdy;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      rx  = 3'b111;
      rdy = 3'b111;
      @(posedge clk);
      #1;
      cycles(3);
      for (int u = 0; u < 3; u++)
         chk($sformatf("reset_outputs_u%0d", u), {dat[u], vld[u], pe[u], fe[u], brk[u], ovr[u], bsy[u]}, 64'd0);
      rst = 1'b0;
      cycles(2 * OSR);

      // model pins
      chk("model_even_par_err", 64'(model_frame(1, 8'h03, 1'b1, 2'b11).pe), 64'd1);
      chk("model_even_par_ok", 64'(model_frame(1, 8'h03, 1'b0, 2'b11).pe), 64'd0);
      chk("model_break", 64'({model_frame(2, 8'h00, 1'b0, 2'b00).fe, model_frame(2, 8'h00, 1'b0, 2'b00).brk}), 64'd3);

      // 8N1 clean frame
      send_frame(0, 8'hA5, 1'b0, 2'b11, 1'b1);
      drain("drain_a5");
      chk("a5_data", 64'(dat[0]), 64'hA5);
      chk("a5_flags", 64'({pe[0], fe[0], brk[0], ovr[0], vld[0]}), 64'd0);

      // even parity
      send_frame(1, 8'h03, 1'b1, 2'b11, 1'b1);
      drain("drain_par1");
      chk("par1_err", 64'({dat[1], pe[1]}), 64'({8'h03, 1'b1}));
      send_frame(1, 8'h03, 1'b0, 2'b11, 1'b1);
      drain("drain_par0");
      chk("par0_err", 64'({dat[1], pe[1]}), 64'({8'h03, 1'b0}));

      // framing error then clean recovery
      send_frame(0, 8'h55, 1'b0, 2'b00, 1'b1);
      drain("drain_55");
      chk("fe_55", 64'({dat[0], fe[0], brk[0]}), 64'({8'h55, 1'b1, 1'b0}));
      send_frame(0, 8'h12, 1'b0, 2'b11, 1'b1);
      drain("drain_12");
      chk("clean_12", 64'({dat[0], fe[0], pe[0]}), 64'({8'h12, 1'b0, 1'b0}));

      // short low glitch is rejected as a false start
      begin
         bit saw;
         saw = 1'b0;
         rx[0] = 1'b0;
         cycles(5);
         rx[0] = 1'b1;
         for (int i = 0; i < 3 * OSR; i++) begin
            cycles(1);
            if (bsy[0]) saw = 1'b1;
         end
         chk("glitch_busy_pulse", 64'(saw), 64'd1);
         chk("glitch_idle", 64'({bsy[0], vld[0]}), 64'd0);
      end

      // overrun: second frame dropped while the first is unconsumed
      rdy[0] = 1'b0;
      send_frame(0, 8'h11, 1'b0, 2'b11, 1'b1);
      send_frame(0, 8'h22, 1'b0, 2'b11, 1'b0);
      drain("drain_11");
      chk("ovr_set", 64'({vld[0], dat[0], ovr[0]}), 64'({1'b1, 8'h11, 1'b1}));
      rdy[0] = 1'b1;
      cycles(2);
      chk("ovr_clear", 64'({vld[0], ovr[0]}), 64'd0);

      // long break on 8N2 produces exactly one report
      exp_q.push_back(model_frame(2, 8'h00, 1'b0, 2'b00));
      rx[2] = 1'b0;
      cycles(20 * OSR);
      chk("break_busy_low_line", 64'(bsy[2]), 64'd1);
      cycles(10 * OSR);
      rx[2] = 1'b1;
      cycles(4 * OSR);
      drain("drain_break");
      chk("break_flags", 64'({dat[2], brk[2], fe[2], pe[2], bsy[2]}), 64'({8'h00, 1'b1, 1'b1, 1'b0, 1'b0}));

      // disabled receiver ignores a frame
      en = 1'b0;
      send_frame(0, 8'h77, 1'b0, 2'b11, 1'b0);
      chk("en_off_idle", 64'({bsy[0], vld[0]}), 64'd0);
      en = 1'b1;
      cycles(2 * OSR);
      chk("en_back_idle", 64'({bsy[0], vld[0]}), 64'd0);

      // reset mid-frame with an unconsumed word pending
      rdy[0] = 1'b0;
      send_frame(0, 8'h44, 1'b0, 2'b11, 1'b1);
      drain("drain_44");
      begin
         logic [7:0] d3c;
         d3c = 8'h3C;
         drive_bit(0, 1'b0);
         for (int i = 0; i < 4; i++) drive_bit(0, d3c[i]);
         rx[0] = d3c[4];
         cycles(OSR / 2);
      end
      chk("mid_frame_busy", 64'({bsy[0], vld[0]}), 64'd3);
      rst = 1'b1;
      #1;
      chk("mid_reset_outputs", {dat[0], vld[0], pe[0], fe[0], brk[0], ovr[0], bsy[0]}, 64'd0);
      rx[0] = 1'b1;
      cycles(3);
      rst = 1'b0;
      cycles(2 * OSR);
      chk("post_reset_idle", 64'({bsy[0], vld[0]}), 64'd0);
      rdy[0] = 1'b1;
      send_frame(0, 8'h3C, 1'b0, 2'b11, 1'b1);
      drain("drain_3c");
      chk("after_reset_3c", 64'({dat[0], fe[0], pe[0], brk[0]}), 64'({8'h3C, 3'b000}));

      cycles(4 * OSR);
      chk("queue_empty_end", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
